mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, SHALL be the fetch address loaded on reset.
REQ-002 Parameter ADDR_BITS, default 16, SHALL be the number of low address bits driven to the RAM; upper ram_addr bits are zero.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: pc_load  in  1, pc_in  in  32  redirect fetch to pc_in.
REQ-007 Port: instr  out  32, instr_valid  out  1, instr_pc  out  32, instr_ready  in  1  instruction buffer and handshake.
REQ-008 Port: d_req  in  1, d_we  in  1, d_addr  in  32, d_wdata  in  32  data access request (d_we=1 write).
REQ-009 Port: d_ack  out  1, d_rdata  out  32  one-cycle completion pulse and read data.
REQ-010 Port: ram_addr  out  32, ram_rw  out  2, ram_din  out  32, ram_en  out  1  RAM command (rw 00 fetch, 01 read, 10 write).
REQ-011 Port: ram_dout  in  32, ram_fetch  in  32  RAM registered outputs, valid one cycle after a command.

Function
REQ-012 FSM states SHALL be IDLE, IFETCH, IWAIT, DACC, DWAIT.
REQ-013 IDLE: d_req=1 and d_ack=0 -> DACC, latching d_we/d_addr/d_wdata; else instr_valid=0 -> IFETCH; else stay.
REQ-014 Data requests SHALL have priority over fetch in IDLE.
REQ-015 IFETCH and IWAIT SHALL drive ram_en=1, ram_rw=00, ram_addr=pc masked to ADDR_BITS.
REQ-016 IFETCH -> IWAIT unconditionally; at end of IWAIT instr<=ram_fetch, instr_valid<=1, state -> IDLE.
REQ-017 Fetch latency: instr_valid SHALL rise exactly 2 cycles after IFETCH is entered.
REQ-018 DACC SHALL drive ram_en=1, latched address, ram_rw=10 with ram_din=latched wdata if write, else ram_rw=01.
REQ-019 Write: DACC -> IDLE, d_ack=1 in the following cycle.
REQ-020 Read: DACC -> DWAIT holding the same command; at end of DWAIT d_rdata<=ram_dout, d_ack=1 next cycle, state -> IDLE.
REQ-021 d_ack SHALL be a single-cycle pulse; d_rdata SHALL hold its value until the next read completes.
REQ-022 Requester holds d_req until d_ack; d_req SHALL be ignored in the cycle d_ack=1.
REQ-023 In IDLE, ram_en=0, ram_rw=00, ram_addr=0, ram_din=0.
REQ-024 instr_pc SHALL equal pc; instr and instr_pc stable while instr_valid=1.
REQ-025 instr_valid=1 and instr_ready=1 in a cycle: instr_valid<=0, pc<=pc+1, wrapping within ADDR_BITS (16'hFFFF -> 0).
REQ-026 pc_load=1: pc<=pc_in, instr_valid<=0; overrides a simultaneous consume.
REQ-027 pc_load in IFETCH/IWAIT SHALL abort the fetch (-> IDLE, nothing captured).
REQ-028 pc_load in DACC/DWAIT SHALL NOT disturb the data access.
REQ-029 Data accesses SHALL be serviced while instr_valid=1 and SHALL NOT alter the buffered instruction.

Reset
REQ-030 rst=1: state IDLE, pc=PC_RESET, instr=0, instr_valid=0, d_ack=0, d_rdata=0.
REQ-031 ram_en SHALL be forced 0 combinationally while rst=1; an in-flight write in that cycle SHALL NOT commit and SHALL NOT be acked.
REQ-032 The first fetch SHALL begin (IFETCH) the cycle after IDLE is entered following rst deassertion.

Verification
REQ-033 Reset release, RAM[0]=32'hA5A5_0001, instr_ready=0 -> instr_valid=1 3 cycles after rst low, instr=32'hA5A5_0001, instr_pc=0, held.
REQ-034 Write d_addr=32'h10, d_wdata=32'hDEAD_BEEF then read 32'h10 -> write ack 2 cycles after request, read ack 3 cycles after, d_rdata=32'hDEAD_BEEF.
REQ-035 d_req and fetch pending together in IDLE -> DACC entered first; IFETCH follows after d_ack.
REQ-036 pc_load=1, pc_in=32'h40 during IWAIT -> no instr_valid from aborted fetch; next instr_pc=32'h40 with RAM[0x40] data.
REQ-037 pc=32'h0000_FFFF consumed -> instr_pc=0, fetch from address 0.
REQ-038 rst asserted in DACC write -> RAM location unchanged, no d_ack, outputs at reset values.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and data load/store onto a
// single-port RAM with registered outputs, and buffers one fetched instruction.
module mem_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] ram_addr,
    output logic [1:0]  ram_rw,
    output logic [31:0] ram_din,
    output logic        ram_en,
    input  logic [31:0] ram_dout,
    input  logic [31:0] ram_fetch
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IFETCH = 3'd1;
    localparam logic [2:0] ST_IWAIT  = 3'd2;
    localparam logic [2:0] ST_DACC   = 3'd3;
    localparam logic [2:0] ST_DWAIT  = 3'd4;

    localparam logic [1:0] RW_FETCH = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32'sd32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << ADDR_BITS) - 32'd1);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        instr_valid_r;
    logic        d_ack_r;
    logic [31:0] d_rdata_r;
    logic        lat_we_r;
    logic [31:0] lat_addr_r;
    logic [31:0] lat_wdata_r;
    logic        data_start_s;
    logic        data_done_s;
    logic        ram_en_s;
    logic [1:0]  ram_rw_s;
    logic [31:0] ram_addr_s;
    logic [31:0] ram_din_s;

    // A request is not accepted in the ack cycle, so a held d_req cannot re-trigger
    assign data_start_s = (state_r == ST_IDLE) && d_req && !d_ack_r;
    assign data_done_s  = ((state_r == ST_DACC) && lat_we_r) || (state_r == ST_DWAIT);

    // Next-state decode: data beats fetch in IDLE; pc_load aborts only a fetch
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (data_start_s) begin
                    state_nxt_s = ST_DACC;
                end else if (!instr_valid_r) begin
                    state_nxt_s = ST_IFETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IFETCH: begin
                if (pc_load) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_IWAIT;
                end
            end
            ST_IWAIT: state_nxt_s = ST_IDLE;
            ST_DACC: begin
                if (lat_we_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DWAIT;
                end
            end
            ST_DWAIT: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the data request when it is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'h0;
            lat_wdata_r <= 32'h0;
        end else if (data_start_s) begin
            lat_we_r    <= d_we;
            lat_addr_r  <= d_addr;
            lat_wdata_r <= d_wdata;
        end
    end

    // Data completion pulse and read-data hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            d_ack_r   <= 1'b0;
            d_rdata_r <= 32'h0;
        end else begin
            d_ack_r <= data_done_s;
            if (state_r == ST_DWAIT) begin
                d_rdata_r <= ram_dout;
            end
        end
    end

    // Instruction buffer and program counter; pc_load wins over a consume
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= PC_RESET;
            instr_r       <= 32'h0;
            instr_valid_r <= 1'b0;
        end else if (pc_load) begin
            pc_r          <= pc_in;
            instr_valid_r <= 1'b0;
        end else if (state_r == ST_IWAIT) begin
            instr_r       <= ram_fetch;
            instr_valid_r <= 1'b1;
        end else if (instr_valid_r && instr_ready) begin
            pc_r          <= (pc_r + 32'd1) & ADDR_MASK;
            instr_valid_r <= 1'b0;
        end
    end

    // RAM command decode from the current state
    always_comb begin
        ram_en_s   = 1'b0;
        ram_rw_s   = RW_FETCH;
        ram_addr_s = 32'h0;
        ram_din_s  = 32'h0;
        case (state_r)
            ST_IFETCH, ST_IWAIT: begin
                ram_en_s   = 1'b1;
                ram_rw_s   = RW_FETCH;
                ram_addr_s = pc_r & ADDR_MASK;
            end
            ST_DACC, ST_DWAIT: begin
                ram_en_s   = 1'b1;
                ram_addr_s = lat_addr_r & ADDR_MASK;
                if (lat_we_r) begin
                    ram_rw_s  = RW_WRITE;
                    ram_din_s = lat_wdata_r;
                end else begin
                    ram_rw_s  = RW_READ;
                    ram_din_s = 32'h0;
                end
            end
            default: begin
                ram_en_s   = 1'b0;
                ram_rw_s   = RW_FETCH;
                ram_addr_s = 32'h0;
                ram_din_s  = 32'h0;
            end
        endcase
    end

    // Reset kills the enable immediately so an in-flight write never lands
    assign ram_en      = ram_en_s & ~rst;
    assign ram_rw      = ram_rw_s;
    assign ram_addr    = ram_addr_s;
    assign ram_din     = ram_din_s;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign instr_pc    = pc_r;
    assign d_ack       = d_ack_r;
    assign d_rdata     = d_rdata_r;

endmodule
